// File: rtl/wave_capture.sv
// Triggered sample-capture buffer: arms on host request, waits for a level
// crossing, stores a decimated record in block RAM, then drains it to the host.
module wave_capture #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              arm,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [15:0]       decim,
  input  logic              rd_en,
  output logic [15:0]       rd_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  state_t state, next_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic [15:0]       dec_cnt;
  logic [ADDR_W:0]   rd_ptr;

  logic              trig_hit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_ok;
  logic              rd_under;

  assign busy = (state == S_ARMED) || (state == S_CAPTURE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    next_state = state;
    trig_hit   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = wr_count[ADDR_W-1:0];
    rd_ok      = 1'b0;
    rd_under   = 1'b0;

    unique case (trig_mode)
      2'b01:   trig_hit = prev_valid && (prev < trig_level) && (sample >= trig_level);
      2'b10:   trig_hit = prev_valid && (prev > trig_level) && (sample <= trig_level);
      default: trig_hit = 1'b1;
    endcase

    if (reset) begin
      next_state = S_IDLE;
    end else if (arm) begin
      // arm overrides any coincident sample or read
      next_state = S_ARMED;
    end else begin
      unique case (state)
        S_ARMED: begin
          if (sample_valid && trig_hit) begin
            wr_en      = 1'b1;
            wr_addr    = '0;
            next_state = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (sample_valid && dec_cnt == 16'd0) wr_en = 1'b1;
        end
        S_DONE: begin
          rd_ok    = rd_en && (rd_ptr < wr_count);
          rd_under = rd_en && (rd_ptr == wr_count);
        end
        default: ;
      endcase
      if (wr_en && wr_count == LAST_IDX) next_state = S_DONE;
    end
  end

  // NOTE: RAM has no reset so it maps onto block RAM; stale contents are never read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= sample;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count   <= '0;
      rd_ptr     <= '0;
      rd_data    <= 16'h0000;
      underrun   <= 1'b0;
      prev       <= '0;
      prev_valid <= 1'b0;
      dec_cnt    <= 16'd0;
    end else if (arm) begin
      wr_count   <= '0;
      rd_ptr     <= '0;
      underrun   <= 1'b0;
      prev_valid <= 1'b0;
      dec_cnt    <= 16'd0;
    end else begin
      if (state == S_ARMED && sample_valid) begin
        prev       <= sample;
        prev_valid <= 1'b1;
      end
      if (wr_en) begin
        wr_count <= wr_count + 1'b1;
        dec_cnt  <= decim;
      end else if (state == S_CAPTURE && sample_valid) begin
        dec_cnt <= dec_cnt - 16'd1;
      end
      if (rd_ok) begin
        rd_data <= 16'(mem[rd_ptr[ADDR_W-1:0]]);
        rd_ptr  <= rd_ptr + 1'b1;
      end else if (rd_under) begin
        rd_data  <= 16'h0000;
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture with DEPTH=16: trigger modes, decimation,
// re-arm, readout/underrun and reset behaviour against hand-computed values.
module tb_wave_capture;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample = '0;
  logic              arm = 1'b0;
  logic [1:0]        trig_mode = 2'b00;
  logic [DATA_W-1:0] trig_level = '0;
  logic [15:0]       decim = 16'd0;
  logic              rd_en = 1'b0;
  logic [15:0]       rd_data;
  logic [ADDR_W:0]   wr_count;
  logic              busy;
  logic              done;
  logic              underrun;

  int n_checks = 0;
  int n_fail   = 0;

  wave_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .arm(arm), .trig_mode(trig_mode), .trig_level(trig_level), .decim(decim),
    .rd_en(rd_en), .rd_data(rd_data), .wr_count(wr_count), .busy(busy),
    .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [DATA_W-1:0] v);
    sample = v; sample_valid = 1'b1;
    cyc();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [DATA_W-1:0] lvl, input logic [15:0] d);
    trig_mode = mode; trig_level = lvl; decim = d;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
  endtask

  initial begin
    cyc(); cyc();
    reset = 1'b0;
    check_idle("reset");
    rd();
    check("idle_rd_data", 32'(rd_data), 32'h0);

    // Immediate mode, no decimation, samples 0..20 every cycle
    do_arm(2'b00, 12'h000, 16'd0);
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_wr_count", 32'(wr_count), 32'd0);
    for (int i = 0; i < 21; i++) begin
      feed(12'(i));
      if (i == 0)  check("imm_first_wr", 32'(wr_count), 32'd1);
      if (i == 14) check("imm_done_early", 32'(done), 32'd0);
      if (i == 15) begin
        check("imm_done", 32'(done), 32'd1);
        check("imm_busy", 32'(busy), 32'd0);
      end
    end
    check("imm_wr_count", 32'(wr_count), 32'd16);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      check($sformatf("imm_rd%0d", i), 32'(rd_data), 32'(i));
    end
    check("imm_no_underrun", 32'(underrun), 32'd0);
    cyc();
    rd_en = 1'b0;
    check("imm_rd17", 32'(rd_data), 32'h0);
    check("imm_underrun", 32'(underrun), 32'd1);

    // Rising crossing at 0x800; first sample above level must not fire
    do_arm(2'b01, 12'h800, 16'd0);
    check("rise_underrun_cleared", 32'(underrun), 32'd0);
    feed(12'h900);
    check("rise_no_first", 32'(wr_count), 32'd0);
    feed(12'h7F0);
    feed(12'h7F8);
    check("rise_not_yet", 32'(wr_count), 32'd0);
    for (int k = 0; k < 16; k++) feed(12'(12'h800 + 8 * k));
    check("rise_done", 32'(done), 32'd1);
    rd();
    check("rise_word0", 32'(rd_data), 32'h0800);
    rd();
    check("rise_word1", 32'(rd_data), 32'h0808);

    // Arm coincident with read in DONE: read ignored
    trig_mode = 2'b10; trig_level = 12'h400; decim = 16'd2;
    arm = 1'b1; rd_en = 1'b1;
    cyc();
    arm = 1'b0; rd_en = 1'b0;
    check("armrd_rd_data", 32'(rd_data), 32'h0808);
    check("armrd_busy", 32'(busy), 32'd1);
    check("armrd_done", 32'(done), 32'd0);
    check("armrd_wr_count", 32'(wr_count), 32'd0);

    // Falling crossing at 0x400 with decim=2
    feed(12'h500);
    check("fall_no_first", 32'(wr_count), 32'd0);
    feed(12'h400);
    check("fall_trig", 32'(wr_count), 32'd1);
    for (int k = 1; k <= 45; k++) begin
      feed(12'(12'h100 + k));
      if (k == 3) check("fall_decim_wr", 32'(wr_count), 32'd2);
      if (k == 44) check("fall_done_early", 32'(done), 32'd0);
    end
    check("fall_done", 32'(done), 32'd1);
    rd_en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      cyc();
      check($sformatf("fall_rd%0d", j), 32'(rd_data), (j == 0) ? 32'h400 : 32'(12'h100 + 3 * j));
    end
    rd_en = 1'b0;

    // Re-arm mid-capture at wr_count=5
    do_arm(2'b00, 12'h000, 16'd0);
    for (int i = 0; i < 5; i++) feed(12'(12'hA00 + i));
    check("mid_wr5", 32'(wr_count), 32'd5);
    do_arm(2'b00, 12'h000, 16'd0);
    check("mid_rearm_wr", 32'(wr_count), 32'd0);
    check("mid_rearm_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) feed(12'(12'hB00 + i));
    check("mid_done", 32'(done), 32'd1);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      check($sformatf("mid_rd%0d", i), 32'(rd_data), 32'(12'hB00 + i));
    end
    rd_en = 1'b0;

    // Reset during CAPTURE
    do_arm(2'b00, 12'h000, 16'd0);
    for (int i = 0; i < 3; i++) feed(12'(12'hC00 + i));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_idle("rst_capture");

    // Reset in DONE mid-readout
    do_arm(2'b00, 12'h000, 16'd0);
    for (int i = 0; i < 16; i++) feed(12'(12'hD00 + i));
    rd(); rd(); rd();
    check("rst_done_pre", 32'(rd_data), 32'h0D02);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_idle("rst_done");
    rd();
    check("rst_idle_rd", 32'(rd_data), 32'h0);
    check("rst_idle_underrun", 32'(underrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
# wave_capture

Triggered sample-capture buffer for the waveform generator output: the read-back path that complements the host-programmed generator. It watches the 12-bit sample stream and its per-sample strobe, waits for a host-armed trigger condition, and stores a decimated record of `DEPTH` samples in on-chip RAM. Once the record is complete, the host drains it word-by-word through a pipe-out-style read strobe. It sits beside the generator in `top`, fed by the same sample strobe and result bus. Arm, trigger and decimation controls come from wire/trigger-ins; data and status go back to the host.

## Interface
- `DEPTH`, 1024, number of samples per record (power of two)
- `ADDR_W`, 10, log2(`DEPTH`)
- `DATA_W`, 12, sample width
- `clk`  in  1  system clock (the generator's `clk1` domain)
- `reset`  in  1  synchronous, active-high; one clock; returns block to IDLE
- `sample_valid`  in  1  one-cycle strobe, new sample present
- `sample`  in  `DATA_W`  unsigned generator output
- `arm`  in  1  one-cycle pulse; start/restart a capture
- `trig_mode`  in  2  00 immediate, 01 rising crossing, 10 falling crossing, 11 treated as 00
- `trig_level`  in  `DATA_W`  unsigned crossing threshold
- `decim`  in  16  store every (`decim`+1)-th valid sample after trigger
- `rd_en`  in  1  host read strobe, one word per asserted cycle
- `rd_data`  out  16  {4'b0000, sample}; reset 16'h0000
- `wr_count`  out  `ADDR_W`+1  samples stored in current record; reset 0
- `busy`  out  1  state is ARMED or CAPTURE; reset 0
- `done`  out  1  state is DONE; reset 0
- `underrun`  out  1  sticky: read attempted past end of record; reset 0

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- `arm` in any state:
  - go to ARMED;
  - clear `wr_count`, read pointer, `underrun`, `prev_valid`;
  - reload decimation counter to 0.
  - `arm` has priority over every other input in the same cycle; a coincident `sample_valid` or `rd_en` is ignored.
- ARMED:
  - each `sample_valid` updates `prev` <= `sample` and sets `prev_valid`.
  - Trigger evaluates on a valid sample, using the old `prev`:
    - mode 00 / 11: always true;
    - mode 01: `prev_valid` && `prev` < `trig_level` && `sample` >= `trig_level`;
    - mode 10: `prev_valid` && `prev` > `trig_level` && `sample` <= `trig_level`.
  - The first valid sample after arm can never fire modes 01/10.
  - On trigger, the triggering sample is written at address 0, the decimation counter loads `decim`, and the state moves to CAPTURE.
- CAPTURE:
  - on each `sample_valid`, if the decimation counter is 0: write the sample at `wr_count`, increment, reload the counter with `decim`;
  - otherwise decrement the counter.
  - `decim` is sampled live; a change takes effect at the next reload.
  - When the write that makes `wr_count` = `DEPTH` occurs, go to DONE.
- DONE:
  - `rd_en` with read pointer < `wr_count`: `rd_data` <= {4'b0, mem[ptr]}, ptr++.
  - `rd_en` with ptr = `wr_count`: `rd_data` <= 16'h0000, set `underrun`, ptr holds.
  - `sample_valid` is ignored.
- `rd_en` outside DONE: ignored; `rd_data` holds; `underrun` unchanged.
- `reset`:
  - IDLE, all outputs at reset values, pointers and `prev_valid` cleared;
  - RAM contents need not be cleared.
  - Mid-capture reset discards the record.
- Widths: `wr_count` and the read pointer are `ADDR_W`+1 bits and never wrap; the decimation counter is 16 bits unsigned.

## Timing
- `arm` at edge t → `busy`=1, `done`=0, `wr_count`=0 after edge t.
- Triggering `sample_valid` at edge t → state CAPTURE and `wr_count`=1 after edge t.
- Final write at edge t → `done`=1, `busy`=0 after edge t; no extra cycle.
- `rd_en` at edge t → `rd_data` valid after edge t (1-cycle registered read latency); back-to-back `rd_en` every cycle sustains one word per cycle.
- RAM: single write port, synchronous read; inferred block RAM.
- Minimum spacing between `sample_valid` pulses: 1 cycle (every cycle allowed).

## Test plan
- Immediate mode, `decim`=0, `DEPTH`=16, samples 0..20 on every cycle → `done` after 16th valid sample. Then 16 `rd_en` return 0x0000..0x000F, and a 17th read returns 0x0000 with `underrun`=1.
- Rising trigger, `trig_level`=0x800, ramp 0x7F0, 0x7F8, 0x800, 0x808… → first stored word 0x0800. A first sample already ≥0x800 right after arm does not trigger.
- Falling trigger, level 0x400, sequence 0x500, 0x400 → trigger on 0x400; with `decim`=2, stored words are samples 0, 3, 6… after the trigger.
- `arm` pulsed mid-CAPTURE with `wr_count`=5 → `wr_count`=0, `busy`=1 next cycle; the new record is independent of the old one. `arm` coincident with `rd_en` in DONE → read ignored, `rd_data` unchanged.
- `reset` asserted in CAPTURE and in DONE mid-readout → `busy`=`done`=`underrun`=0, `rd_data`=0x0000, `wr_count`=0 next cycle. `rd_en` in IDLE leaves `rd_data` at 0x0000.
